// File: rtl/arb3_onehot_sel.sv
// arb3_onehot_sel: three-requester round-robin arbiter that drives the
// registered one-hot select of the 3:1 one-hot data mux (bit i -> input di).
// Optional macro ARB3_TIMEOUT_EN builds the tenure counter and forces a
// release after MAX_HOLD cycles of ownership. Without it, ownership ends only
// on done or on the owner's request dropping.
//
// Handshake: this block has no valid/ready pair. A requester holds req[i]
// high while it wants the mux. It owns the mux while select[i]=1, and it
// signals completion with a one-cycle done pulse (done is ignored in IDLE).
// Every output is a flop. select is one-hot while busy and 000 while idle.
module arb3_onehot_sel #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] select,
  output logic       busy,
  output logic [1:0] owner,
  output logic [0:0] dbg_state
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Reject out-of-range hold limits at elaboration time.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arb3_onehot_sel: MAX_HOLD must be in 2..255");
  end

  logic [0:0] state;
  logic [1:0] last;
  logic [4:0] pick_idle;
  logic [4:0] pick_rel;
  logic       timeout_hit;
  logic       release_now;

  // Round-robin pick: search last+1, last+2, last (mod 3).
  // Returns {one-hot select, binary index}, or all zeros when nobody requests.
  function automatic logic [4:0] rr_pick(input logic [1:0] lst, input logic [2:0] r);
    logic [1:0] o0, o1, o2;
    case (lst)
      2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
      2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
      default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
    endcase
    if (r[o0])      rr_pick = {3'b001 << o0, o0};
    else if (r[o1]) rr_pick = {3'b001 << o1, o1};
    else if (r[o2]) rr_pick = {3'b001 << o2, o2};
    else            rr_pick = 5'b0;
  endfunction

  // From IDLE the pointer is last. On a release the departing owner becomes
  // the new pointer, so it ranks lowest in the re-pick.
  assign pick_idle = rr_pick(last, req);
  assign pick_rel  = rr_pick(owner, req);

`ifdef ARB3_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt;

  assign timeout_hit = (cnt == CW'(MAX_HOLD - 1));

  // Tenure counter: restarts at every new grant and saturates at MAX_HOLD-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (state == IDLE || release_now) begin
      cnt <= '0;
    end else if (!timeout_hit) begin
      cnt <= cnt + CW'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // done together with a timeout is a single release. Other requesters never preempt.
  assign release_now = done | ~req[owner] | timeout_hit;

  assign dbg_state = state;

  // Ownership FSM. Hand-over goes straight from one one-hot code to the next.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      select <= 3'b000;
      busy   <= 1'b0;
      owner  <= 2'd0;
      last   <= 2'd2;
    end else begin
      case (state)
        IDLE: begin
          if (pick_idle[4:2] != 3'b000) begin
            state  <= GRANT;
            select <= pick_idle[4:2];
            owner  <= pick_idle[1:0];
            busy   <= 1'b1;
          end
        end
        default: begin
          if (release_now) begin
            last <= owner;
            if (pick_rel[4:2] != 3'b000) begin
              select <= pick_rel[4:2];
              owner  <= pick_rel[1:0];
            end else begin
              state  <= IDLE;
              select <= 3'b000;
              busy   <= 1'b0;
              owner  <= 2'd0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arb3_onehot_sel.sv
// tb_arb3_onehot_sel: directed scoreboard bench for arb3_onehot_sel.
// The driver applies req/done on the falling edge and queues the expected
// {select, busy, owner} for after the next rising edge. The monitor pops one
// entry per rising edge and compares. Built with MAX_HOLD=4, so the tenure test
// selects its expectations from ARB3_TIMEOUT_EN.
module tb_arb3_onehot_sel;

  logic       clk;
  logic       reset;
  logic [2:0] req;
  logic       done;
  logic [2:0] select;
  logic       busy;
  logic [1:0] owner;
  logic [0:0] dbg_state;

  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  arb3_onehot_sel #(.MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .select(select), .busy(busy), .owner(owner), .dbg_state(dbg_state)
  );

  // Clock and reset.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got sel=%b busy=%b own=%0d, want sel=%b busy=%b own=%0d",
               name, act[5:3], act[2], act[1:0], exp[5:3], exp[2], exp[1:0]);
    end
  endtask

  // Driver: apply inputs for one cycle and queue the expected outputs after the edge.
  task automatic step(input logic [2:0] r, input logic d, input logic [2:0] es,
                      input logic eb, input logic [1:0] eo);
    @(negedge clk);
    req  = r;
    done = d;
    exp_q.push_back({es, eb, eo});
  endtask

  // Monitor: one scoreboard entry per rising edge, sampled 1ns after the edge.
  initial begin
    logic [5:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_outputs", {select, busy, owner}, e);
        n_checks++;
        if (!((select == 3'b000 && !busy) || (busy && $onehot(select)))) begin
          n_fail++;
          $display("FAIL select_legal: got sel=%b busy=%b, want one-hot when busy else 000",
                   select, busy);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    req   = 3'b000;
    done  = 1'b0;
    #3;
    check("reset_state", {select, busy, owner}, 6'b000_0_00);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Full rotation with req=111 and one done pulse per grant.
    step(3'b111, 1'b0, 3'b001, 1'b1, 2'd0);
    step(3'b111, 1'b1, 3'b010, 1'b1, 2'd1);
    step(3'b111, 1'b1, 3'b100, 1'b1, 2'd2);
    step(3'b111, 1'b1, 3'b001, 1'b1, 2'd0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'd0);   // last=0

    // Single requester 1 from idle, then drop it.
    step(3'b010, 1'b0, 3'b010, 1'b1, 2'd1);
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'd0);   // last=1

    // Hand-over with no idle gap. The departing sole requester wins again.
    step(3'b001, 1'b0, 3'b001, 1'b1, 2'd0);
    step(3'b101, 1'b1, 3'b100, 1'b1, 2'd2);
    step(3'b001, 1'b1, 3'b001, 1'b1, 2'd0);
    step(3'b001, 1'b1, 3'b001, 1'b1, 2'd0);
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'd0);   // last=0

    // Other requesters never preempt. Release when req[owner] drops.
    step(3'b001, 1'b0, 3'b001, 1'b1, 2'd0);
    step(3'b111, 1'b0, 3'b001, 1'b1, 2'd0);
    step(3'b111, 1'b0, 3'b001, 1'b1, 2'd0);
    step(3'b110, 1'b0, 3'b010, 1'b1, 2'd1);
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'd0);   // last=1

    // Tenure test: req=011 held with done=0, starting at last=1, so owner 0 wins first.
`ifdef ARB3_TIMEOUT_EN
    for (int i = 0; i < 12; i++) begin
      if (i < 4 || i >= 8) step(3'b011, 1'b0, 3'b001, 1'b1, 2'd0);
      else                 step(3'b011, 1'b0, 3'b010, 1'b1, 2'd1);
    end
`else
    for (int i = 0; i < 20; i++) step(3'b011, 1'b0, 3'b001, 1'b1, 2'd0);
`endif
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'd0);   // last=0

    // Asynchronous reset in the middle of a grant to requester 2.
    step(3'b100, 1'b0, 3'b100, 1'b1, 2'd2);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_clears", {select, busy, owner}, 6'b000_0_00);
    @(negedge clk);
    reset = 1'b0;
    req   = 3'b111;
    done  = 1'b0;
    exp_q.push_back({3'b001, 1'b1, 2'd0});    // last was reset to 2
    step(3'b000, 1'b0, 3'b000, 1'b0, 2'd0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
